// File: rtl/mmu_pkg.sv
// Shared MMU types: dmem request/response bundles and arbiter owner tags.
// Imported by the dmem/PTW arbiter and its owner FIFO.
package mmu_pkg;

  localparam int DMEM_ARB_OUTSTANDING = 4;
  localparam int DMEM_PADDR_W = 40;
  localparam int DMEM_DATA_W = 64;

  typedef enum logic {
    OWNER_CORE = 1'b0,
    OWNER_PTW  = 1'b1
  } dmem_owner_t;

  typedef struct packed {
    logic                    valid;
    logic [DMEM_PADDR_W-1:0] addr;
    logic [4:0]              cmd;
    logic [2:0]              typ;
    logic                    phys;
    logic                    kill;
    logic [DMEM_DATA_W-1:0]  data;
  } dmem_req_t;

  typedef struct packed {
    dmem_req_t req;
  } ptw_dmem_comm_t;

  typedef struct packed {
    logic                   valid;
    logic                   nack;
    logic [DMEM_DATA_W-1:0] data;
  } dmem_resp_t;

  typedef struct packed {
    logic       dmem_ready;
    dmem_resp_t resp;
  } dmem_ptw_comm_t;

endpackage

// File: rtl/dmem_arb_owner_fifo.sv
// Owner-tag FIFO: records who owns each in-flight dmem request, in order.
// Ports: clk_i, rst_i, push_i/owner_i, pop_i, full_o, empty_o, head_o.
module dmem_arb_owner_fifo
  import mmu_pkg::*;
#(
  parameter int DEPTH = DMEM_ARB_OUTSTANDING
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        push_i,
  input  dmem_owner_t owner_i,
  input  logic        pop_i,
  output logic        full_o,
  output logic        empty_o,
  output dmem_owner_t head_o
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] P_ONE = 1;
  localparam logic [PW:0] C_ONE = 1;
  localparam logic [PW:0] C_FULL = (PW+1)'(DEPTH);

  dmem_owner_t   r_mem [DEPTH];
  logic [PW-1:0] r_wr;
  logic [PW-1:0] r_rd;
  logic [PW:0]   r_cnt;

  always_ff @(posedge clk_i) begin
    if (push_i) r_mem[r_wr] <= owner_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (push_i) r_wr <= r_wr + P_ONE;
      if (pop_i) r_rd <= r_rd + P_ONE;
      unique case ({push_i, pop_i})
        2'b10:   r_cnt <= r_cnt + C_ONE;
        2'b01:   r_cnt <= r_cnt - C_ONE;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign full_o  = (r_cnt == C_FULL);
  assign empty_o = (r_cnt == '0);
  assign head_o  = r_mem[r_rd];

endmodule

// File: rtl/dmem_ptw_arb.sv
// Arbitrates PTW and core LSU onto one L1D port; routes responses by owner.
// Ports: clk_i, rst_i, PTW/core req in, per-side ready+resp out, L1D side, orphan_err_o.
module dmem_ptw_arb
  import mmu_pkg::*;
#(
  parameter int OUTSTANDING  = DMEM_ARB_OUTSTANDING,
  parameter int STARVE_LIMIT = 8
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  ptw_dmem_comm_t ptw_dmem_comm_i,
  output dmem_ptw_comm_t dmem_ptw_comm_o,
  input  ptw_dmem_comm_t core_dmem_comm_i,
  output dmem_ptw_comm_t dmem_core_comm_o,
  output ptw_dmem_comm_t dmem_req_o,
  input  dmem_ptw_comm_t dmem_resp_i,
  output logic           orphan_err_o
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] S_MAX = SW'(STARVE_LIMIT);
  localparam logic [SW-1:0] S_ONE = 1;

  logic [SW-1:0] r_starve;
  logic          r_last_core;
  logic          r_orphan;

  logic          w_pv;
  logic          w_cv;
  logic          w_rdy;
  logic          w_full;
  logic          w_empty;
  logic          w_gnt_ptw;
  logic          w_gnt_core;
  logic          w_acc_ptw;
  logic          w_acc_core;
  logic          w_rsp;
  logic          w_pop;
  logic          w_orph;
  logic          w_to_ptw;
  logic          w_to_core;
  dmem_owner_t   w_head;
  dmem_owner_t   w_push_owner;

  always_comb begin
    w_pv  = ptw_dmem_comm_i.req.valid & ~rst_i;
    w_cv  = core_dmem_comm_i.req.valid & ~rst_i;
    w_rdy = dmem_resp_i.dmem_ready & ~rst_i;
    // A full tracker blocks grant outright; a same-cycle pop does not help.
    w_gnt_ptw  = ~w_full & w_pv & (~w_cv | (r_starve != S_MAX));
    w_gnt_core = ~w_full & w_cv & ~w_gnt_ptw;
    w_acc_ptw  = w_gnt_ptw & w_rdy;
    w_acc_core = w_gnt_core & w_rdy;
    w_push_owner = w_acc_ptw ? OWNER_PTW : OWNER_CORE;
    w_rsp  = (dmem_resp_i.resp.valid | dmem_resp_i.resp.nack) & ~rst_i;
    w_pop  = w_rsp & ~w_empty;
    w_orph = w_rsp & w_empty;
    w_to_ptw  = w_pop & (w_head == OWNER_PTW);
    w_to_core = w_pop & (w_head == OWNER_CORE);
  end

  dmem_arb_owner_fifo #(
    .DEPTH(OUTSTANDING)
  ) u_owner_fifo (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .push_i (w_acc_ptw | w_acc_core),
    .owner_i(w_push_owner),
    .pop_i  (w_pop),
    .full_o (w_full),
    .empty_o(w_empty),
    .head_o (w_head)
  );

  always_comb begin
    dmem_req_o = w_gnt_ptw ? ptw_dmem_comm_i : core_dmem_comm_i;
    dmem_req_o.req.valid = w_gnt_ptw | w_gnt_core;
    // Kill qualifies the request accepted one cycle earlier, core only.
    dmem_req_o.req.kill = r_last_core & core_dmem_comm_i.req.kill & ~rst_i;

    dmem_ptw_comm_o.dmem_ready = w_gnt_ptw & w_rdy;
    dmem_ptw_comm_o.resp.valid = w_to_ptw & dmem_resp_i.resp.valid;
    dmem_ptw_comm_o.resp.nack  = w_to_ptw & dmem_resp_i.resp.nack;
    dmem_ptw_comm_o.resp.data  = dmem_resp_i.resp.data;

    dmem_core_comm_o.dmem_ready = w_gnt_core & w_rdy;
    dmem_core_comm_o.resp.valid = w_to_core & dmem_resp_i.resp.valid;
    dmem_core_comm_o.resp.nack  = w_to_core & dmem_resp_i.resp.nack;
    dmem_core_comm_o.resp.data  = dmem_resp_i.resp.data;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_starve    <= '0;
      r_last_core <= 1'b0;
      r_orphan    <= 1'b0;
    end else begin
      r_last_core <= w_acc_core;
      if (w_orph) r_orphan <= 1'b1;
      if (w_cv && w_acc_ptw) begin
        if (r_starve != S_MAX) r_starve <= r_starve + S_ONE;
      end else if (w_acc_core || !w_cv) begin
        r_starve <= '0;
      end
    end
  end

  assign orphan_err_o = r_orphan;

endmodule

// File: tb/tb_dmem_ptw_arb.sv
// Scoreboard bench for dmem_ptw_arb: owner queue checks grant and routing.
// Directed scenarios followed by a random phase.
module tb_dmem_ptw_arb;
  import mmu_pkg::*;

  localparam int OUT = 4;
  localparam int SL  = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  ptw_dmem_comm_t ptw_i;
  ptw_dmem_comm_t core_i;
  dmem_ptw_comm_t resp_i;
  dmem_ptw_comm_t ptw_o;
  dmem_ptw_comm_t core_o;
  ptw_dmem_comm_t req_o;
  logic           orph_o;

  int n_cmp = 0;
  int n_bad = 0;

  int m_q[$];
  int m_starve = 0;
  bit m_last = 1'b0;
  bit m_orph = 1'b0;

  always #5 clk = ~clk;

  dmem_ptw_arb #(
    .OUTSTANDING (OUT),
    .STARVE_LIMIT(SL)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .ptw_dmem_comm_i (ptw_i),
    .dmem_ptw_comm_o (ptw_o),
    .core_dmem_comm_i(core_i),
    .dmem_core_comm_o(core_o),
    .dmem_req_o      (req_o),
    .dmem_resp_i     (resp_i),
    .orphan_err_o    (orph_o)
  );

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // win/own: 0 none, 1 core, 2 ptw
  task automatic cyc(input bit r, input bit pv, input bit cv,
                     input bit ck, input bit rdy,
                     input bit rv, input bit rn);
    int win;
    int own;
    bit acc;
    bit orph_n;
    @(negedge clk);
    rst = r;
    ptw_i = '0;
    ptw_i.req.valid = pv;
    ptw_i.req.addr = {8'h10, 32'($urandom)};
    ptw_i.req.kill = 1'b1;
    core_i = '0;
    core_i.req.valid = cv;
    core_i.req.addr = {8'h20, 32'($urandom)};
    core_i.req.kill = ck;
    resp_i = '0;
    resp_i.dmem_ready = rdy;
    resp_i.resp.valid = rv;
    resp_i.resp.nack = rn;
    resp_i.resp.data = {32'($urandom), 32'($urandom)};
    #1;
    check("orphan", orph_o, m_orph);
    check("ptw_data", ptw_o.resp.data, resp_i.resp.data);
    check("core_data", core_o.resp.data, resp_i.resp.data);
    if (r) begin
      check("rst_ptw_rdy", ptw_o.dmem_ready, 0);
      check("rst_core_rdy", core_o.dmem_ready, 0);
      check("rst_req_v", req_o.req.valid, 0);
      check("rst_kill", req_o.req.kill, 0);
      check("rst_rsp", {ptw_o.resp.valid, ptw_o.resp.nack,
                        core_o.resp.valid, core_o.resp.nack}, 0);
      m_q.delete();
      m_starve = 0;
      m_last = 1'b0;
      m_orph = 1'b0;
      return;
    end
    if (m_q.size() == OUT) win = 0;
    else if (pv && cv) win = (m_starve == SL) ? 1 : 2;
    else if (pv) win = 2;
    else if (cv) win = 1;
    else win = 0;
    check("core_rdy", core_o.dmem_ready, (win == 1) && rdy);
    check("ptw_rdy", ptw_o.dmem_ready, (win == 2) && rdy);
    check("req_v", req_o.req.valid, win != 0);
    if (win != 0)
      check("req_addr", req_o.req.addr,
            (win == 2) ? ptw_i.req.addr : core_i.req.addr);
    check("kill", req_o.req.kill, m_last && ck);
    own = 0;
    orph_n = 1'b0;
    if (rv || rn) begin
      if (m_q.size() > 0) own = m_q.pop_front();
      else orph_n = 1'b1;
    end
    check("core_rv", core_o.resp.valid, (own == 1) && rv);
    check("core_rn", core_o.resp.nack, (own == 1) && rn);
    check("ptw_rv", ptw_o.resp.valid, (own == 2) && rv);
    check("ptw_rn", ptw_o.resp.nack, (own == 2) && rn);
    acc = (win != 0) && rdy;
    if (acc) m_q.push_back(win);
    if (cv && win == 2 && rdy) begin
      if (m_starve < SL) m_starve++;
    end else if ((win == 1 && rdy) || !cv) begin
      m_starve = 0;
    end
    m_last = acc && (win == 1);
    if (orph_n) m_orph = 1'b1;
  endtask

  initial begin
    ptw_i = '0;
    core_i = '0;
    resp_i = '0;
    // reset
    cyc(1, 1, 1, 1, 1, 1, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    // both valid -> PTW wins; response routed to PTW
    cyc(0, 1, 1, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 0);
    // starvation: core wins on 9th contended cycle
    cyc(0, 1, 1, 0, 1, 0, 0);
    for (int i = 0; i < 8; i++) cyc(0, 1, 1, 0, 1, 1, 0);
    cyc(0, 1, 1, 0, 1, 1, 0);
    cyc(0, 0, 0, 0, 0, 1, 0);
    // fill tracker with core, kill asserted
    for (int i = 0; i < 4; i++) cyc(0, 0, 1, 1, 1, 0, 0);
    cyc(0, 1, 1, 1, 1, 1, 0);
    cyc(0, 0, 1, 1, 1, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0, 1, 0);
    // C,P,C then nack,valid,valid
    cyc(0, 0, 1, 0, 1, 0, 0);
    cyc(0, 1, 0, 0, 1, 0, 0);
    cyc(0, 0, 1, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 1, 0);
    // orphan with empty tracker, sticky
    cyc(0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 0, 0);
    // reset with 3 in flight -> responses become orphans
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, 1, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    // random phase
    cyc(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 400; i++)
      cyc(($urandom_range(0, 99) == 0),
          1'($urandom), 1'($urandom), 1'($urandom),
          ($urandom_range(0, 3) != 0),
          ($urandom_range(0, 2) == 0),
          ($urandom_range(0, 7) == 0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
